// File: rtl/pipe_stage_if.sv
// Handshake bundle for pipe_stage: upstream offer, downstream delivery, flush and occupancy.
// The master modport is the environment side; the slave modport is the stage itself.
interface pipe_stage_if #(
    parameter int unsigned DATA_W = 87
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occ;

    modport master (
        output flush,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  occ
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output occ
    );
endinterface

// File: rtl/pipe_stage.sv
// Registered pipeline stage: output entry plus, when PIPE_STAGE_SKID_EN is defined,
// a skid entry so in_ready can be registered. Default build is a single-entry stage.
module pipe_stage #(
    parameter int unsigned       DATA_W    = 87,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
    input logic         clk,
    input logic         rst_n,
    pipe_stage_if.slave bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [1:0]        occ_q, occ_d;
    logic              in_ready_w;
    logic              acc, cons;

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_ready_q, in_ready_d;

    assign in_ready_w = in_ready_q;
`else
    assign in_ready_w = !out_valid_q || bus.out_ready;
`endif

    assign acc  = bus.in_valid && in_ready_w;
    assign cons = out_valid_q && bus.out_ready;

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_data_d = skid_data_q;
`endif
        if (bus.flush) begin
            // flush wins over any accept/consume on the same edge
            state_d    = ST_EMPTY;
            out_data_d = NOP_VALUE;
`ifdef PIPE_STAGE_SKID_EN
            skid_data_d = '0;
`endif
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        state_d    = ST_HOLD;
                        out_data_d = bus.in_data;
                    end
                end
                ST_HOLD: begin
                    if (cons && acc) begin
                        out_data_d = bus.in_data;
                    end else if (cons) begin
                        state_d    = ST_EMPTY;
                        out_data_d = NOP_VALUE;
                    end
`ifdef PIPE_STAGE_SKID_EN
                    else if (acc) begin
                        state_d     = ST_SKID;
                        skid_data_d = bus.in_data;
                    end
`endif
                end
`ifdef PIPE_STAGE_SKID_EN
                ST_SKID: begin
                    // in_ready is low here, so only a consume can move things
                    if (cons) begin
                        state_d     = ST_HOLD;
                        out_data_d  = skid_data_q;
                        skid_data_d = '0;
                    end
                end
`endif
                default: begin
                    state_d    = ST_EMPTY;
                    out_data_d = NOP_VALUE;
                end
            endcase
        end

        out_valid_d = (state_d != ST_EMPTY);
        case (state_d)
            ST_HOLD: occ_d = 2'd1;
            ST_SKID: occ_d = 2'd2;
            default: occ_d = 2'd0;
        endcase
`ifdef PIPE_STAGE_SKID_EN
        in_ready_d = (state_d != ST_SKID);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_data_q  <= NOP_VALUE;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
`ifdef PIPE_STAGE_SKID_EN
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            occ_q       <= occ_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.occ       = occ_q;

endmodule
